imm_seq_encoder: RTL

//  Inverse of the pipeline's immediate extender: turns a 32-bit constant or a branch target into

---
 rtl/imm_enc_pkg.sv | 41 ++++
 rtl/imm_enc_classify.sv | 103 ++++++++++
 rtl/imm_seq_encoder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/imm_enc_pkg.sv
// -----------------------------------------------------------------------------
// imm_enc_pkg
// Shared constants and types for the immediate/branch-offset sequence encoder:
//   - MIPS opcodes used by the encoder (ADDIU, ORI, LUI, BEQ)
//   - request kinds (load-immediate, BEQ offset encode)
//   - encoder FSM state encoding
//   - load-immediate class (A: ADDIU, B: ORI, C: LUI, D: LUI+ORI)
//   - helper that packs an I-type instruction word
// -----------------------------------------------------------------------------
package imm_enc_pkg;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic KIND_LI  = 1'b0;
  localparam logic KIND_BEQ = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_A = 2'd0,
    CLS_B = 2'd1,
    CLS_C = 2'd2,
    CLS_D = 2'd3
  } li_class_t;

  // I-type layout: opcode | rs | rt | imm16
  function automatic logic [31:0] itype(input logic [5:0]  op,
                                        input logic [4:0]  rs,
                                        input logic [4:0]  rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/imm_enc_classify.sv
// -----------------------------------------------------------------------------
// imm_enc_classify
// Combinational request decoder. For a load-immediate it picks the cheapest
// instruction sequence whose immediates re-extend to the constant; for a BEQ
// it computes the word offset from pc+4 and checks it fits a signed 16-bit
// field.
// Configuration macro: IMMENC_BRANCH_EN (when undefined, every BEQ request is
// reported unencodable and the offset adder is not built).
// Ports:
//   i_kind    request kind (KIND_LI / KIND_BEQ)
//   i_value   LI constant or branch target byte address
//   i_pc      byte address of the branch instruction
//   i_rs      BEQ rs
//   i_rt      LI destination / BEQ rt
//   o_instr1  first instruction beat
//   o_instr2  second beat (only meaningful when o_two)
//   o_two     request needs two beats
//   o_err     request not encodable (o_instr1 = NOP_WORD)
// -----------------------------------------------------------------------------
module imm_enc_classify
  import imm_enc_pkg::*;
#(
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter int          ALLOW_ADDIU = 1
) (
  input  logic        i_kind,
  input  logic [31:0] i_value,
  input  logic [31:0] i_pc,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  output logic [31:0] o_instr1,
  output logic [31:0] o_instr2,
  output logic        o_two,
  output logic        o_err
);

  logic [15:0] w_lo;
  logic [15:0] w_hi;
  logic        w_sext;
  li_class_t   w_class;
  logic [31:0] w_li_instr;

  assign w_lo   = i_value[15:0];
  assign w_hi   = i_value[31:16];
  // Sign-extendable from 16 bits when bits 31..15 are all equal.
  assign w_sext = (&i_value[31:15]) | (~|i_value[31:15]);

  always_comb begin
    if ((ALLOW_ADDIU != 0) && w_sext) begin
      w_class = CLS_A;
    end else if (w_hi == 16'h0000) begin
      w_class = CLS_B;
    end else if (w_lo == 16'h0000) begin
      w_class = CLS_C;
    end else begin
      w_class = CLS_D;
    end
  end

  always_comb begin
    case (w_class)
      CLS_A:   w_li_instr = itype(OP_ADDIU, 5'd0, i_rt, w_lo);
      CLS_B:   w_li_instr = itype(OP_ORI,   5'd0, i_rt, w_lo);
      default: w_li_instr = itype(OP_LUI,   5'd0, i_rt, w_hi);
    endcase
  end

`ifdef IMMENC_BRANCH_EN
  logic [31:0] w_diff;
  logic        w_beq_ok;

  assign w_diff   = i_value - (i_pc + 32'd4);
  // Word aligned and bits 31..17 all equal, so D[17:2] sign-extends back to D.
  assign w_beq_ok = (w_diff[1:0] == 2'b00) &&
                    ((&w_diff[31:17]) | (~|w_diff[31:17]));
`else
  logic w_unused_beq;
  assign w_unused_beq = ^{i_pc, i_rs};
`endif

  always_comb begin
    o_instr1 = w_li_instr;
    o_instr2 = itype(OP_ORI, i_rt, i_rt, w_lo);
    o_two    = 1'b0;
    o_err    = 1'b0;
    if (i_kind == KIND_LI) begin
      o_two = (w_class == CLS_D);
    end else begin
`ifdef IMMENC_BRANCH_EN
      if (w_beq_ok) begin
        o_instr1 = itype(OP_BEQ, i_rs, i_rt, w_diff[17:2]);
      end else begin
        o_instr1 = NOP_WORD;
        o_err    = 1'b1;
      end
`else
      o_instr1 = NOP_WORD;
      o_err    = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/imm_seq_encoder.sv
// -----------------------------------------------------------------------------
// imm_seq_encoder
// Turns a 32-bit constant or a branch target into MIPS instruction words whose
// 16-bit immediates re-extend to the requested value. One request per
// in_valid/in_ready handshake; one or two registered output beats.
// Configuration macro: IMMENC_BRANCH_EN (enables BEQ offset encoding).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   in_valid     request present
//   in_ready     high only while idle
//   in_kind      0 = load-immediate, 1 = BEQ offset encode
//   in_value     LI constant or branch target byte address
//   in_pc        byte address of the branch instruction
//   in_rs        BEQ rs
//   in_rt        LI destination / BEQ rt
//   out_valid    instruction beat present
//   out_ready    consumer accepts the beat
//   out_instr    encoded instruction
//   out_last     final beat of this request
//   out_err      request not encodable; out_instr = NOP_WORD
// -----------------------------------------------------------------------------
module imm_seq_encoder
  import imm_enc_pkg::*;
#(
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000,
  parameter int          ALLOW_ADDIU = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [31:0] in_value,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_err
);

  state_t      r_state;
  state_t      w_nxt_state;
  logic        r_out_valid;
  logic [31:0] r_out_instr;
  logic        r_out_last;
  logic        r_out_err;
  logic [31:0] r_instr2;

  logic        w_nxt_valid;
  logic [31:0] w_nxt_instr;
  logic        w_nxt_last;
  logic        w_nxt_err;
  logic [31:0] w_nxt_instr2;

  logic [31:0] w_instr1;
  logic [31:0] w_instr2;
  logic        w_two;
  logic        w_err;

  imm_enc_classify #(
    .NOP_WORD    (NOP_WORD),
    .ALLOW_ADDIU (ALLOW_ADDIU)
  ) u_classify (
    .i_kind   (in_kind),
    .i_value  (in_value),
    .i_pc     (in_pc),
    .i_rs     (in_rs),
    .i_rt     (in_rt),
    .o_instr1 (w_instr1),
    .o_instr2 (w_instr2),
    .o_two    (w_two),
    .o_err    (w_err)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_last  = r_out_last;
  assign out_err   = r_out_err;

  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_valid  = r_out_valid;
    w_nxt_instr  = r_out_instr;
    w_nxt_last   = r_out_last;
    w_nxt_err    = r_out_err;
    w_nxt_instr2 = r_instr2;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_nxt_state  = EMIT1;
          w_nxt_valid  = 1'b1;
          w_nxt_instr  = w_instr1;
          w_nxt_last   = ~w_two;
          w_nxt_err    = w_err;
          w_nxt_instr2 = w_instr2;
        end
      end
      EMIT1: begin
        if (out_ready) begin
          // out_last low on beat 1 marks a two-beat request.
          if (!r_out_last) begin
            w_nxt_state = EMIT2;
            w_nxt_instr = r_instr2;
            w_nxt_last  = 1'b1;
            w_nxt_err   = 1'b0;
          end else begin
            w_nxt_state = IDLE;
            w_nxt_valid = 1'b0;
          end
        end
      end
      EMIT2: begin
        if (out_ready) begin
          w_nxt_state = IDLE;
          w_nxt_valid = 1'b0;
        end
      end
      default: begin
        w_nxt_state = IDLE;
        w_nxt_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_out_instr <= 32'h0000_0000;
      r_out_last  <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_out_valid <= w_nxt_valid;
      r_out_instr <= w_nxt_instr;
      r_out_last  <= w_nxt_last;
      r_out_err   <= w_nxt_err;
    end
  end

  // Second-beat word is pure data; it is only read after a fresh capture.
  always_ff @(posedge clk) begin
    r_instr2 <= w_nxt_instr2;
  end

endmodule
